// File: rtl/dwrr_queue_arbiter_pkg.sv
// Shared constants and helpers for the DWRR queue arbiter.
// Provides default parameter values, derived width functions and the
// slice-offset helper used to index the flattened per-requestor buses.
package dwrr_queue_arbiter_pkg;

    localparam int unsigned DEF_NUM_REQS = 4;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_DEPTH    = 8;
    localparam int unsigned DEF_QWID     = 8;
    localparam int unsigned DEF_PSIZE    = 8;

    // FIFO occupancy counter width: must hold 0..DEPTH inclusive
    function automatic int unsigned cnt_wid(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Deficit width: one bit of headroom over a quantum
    function automatic int unsigned def_wid(input int unsigned qwid);
        return qwid + 1;
    endfunction

    // Low bit of lane idx in a flattened bus of lanes w bits wide
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/dwrr_req_fifo.sv
// Single-requestor synchronous FIFO with combinational head.
// Ports: clk, rst (sync active-low), push/din write side, pop read side,
//        head_c (current head, combinational), empty/full (registered).
// A push while full is dropped even if a pop happens in the same cycle.
module dwrr_req_fifo
    import dwrr_queue_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head_c,
    output logic             empty,
    output logic             full
);

    localparam int unsigned CNTWID = cnt_wid(DEPTH);
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNTWID-1:0] count;
    logic [CNTWID-1:0] count_nxt;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy update; simultaneous push and pop leave it unchanged
    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CNTWID'(1);
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - CNTWID'(1);
        end
    end

    // Pointers, count and flags; flags track the next count so they stay registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNTWID'(DEPTH));
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dwrr_queue_arbiter.sv
// NUM_REQS ingress FIFOs drained by a deficit-weighted round-robin arbiter.
// Ports: clk, rst (sync active-low), push/flat_data_in per-FIFO writes,
//        input_quantums per-requestor quantum, blk suppresses grants,
//        gnt one-hot grant (= FIFO pop), data_out/data_out_vld granted head,
//        empty/full per-FIFO status.
// gnt, data_out and data_out_vld are combinational from state and inputs.
module dwrr_queue_arbiter
    import dwrr_queue_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQS = DEF_NUM_REQS,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned QWID     = DEF_QWID,
    parameter int unsigned PSIZE    = DEF_PSIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQS-1:0]      push,
    input  logic [NUM_REQS*WIDTH-1:0] flat_data_in,
    input  logic [NUM_REQS*QWID-1:0] input_quantums,
    input  logic                     blk,
    output logic [NUM_REQS-1:0]      gnt,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_out_vld,
    output logic [NUM_REQS-1:0]      empty,
    output logic [NUM_REQS-1:0]      full
);

    localparam int unsigned DWID = def_wid(QWID);
    localparam int unsigned SW   = DWID + 1;
    localparam int unsigned PW   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam logic [DWID-1:0] DMAX = '1;

    logic [WIDTH-1:0] head    [NUM_REQS];
    logic [QWID-1:0]  quantum [NUM_REQS];
    logic [DWID-1:0]  deficit [NUM_REQS];

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   ptr_adv;
    logic            credited;
    logic            credited_nxt;
    logic [DWID-1:0] def_nxt;
    logic            def_we;
    logic [DWID-1:0] cur_def;
    logic [SW-1:0]   sum;
    logic [DWID-1:0] eff;

    // Per-requestor FIFOs; each pop is exactly its grant bit
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_req
        assign quantum[g] = input_quantums[slice_lo(g, QWID) +: QWID];

        dwrr_req_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push   (push[g]),
            .pop    (gnt[g]),
            .din    (flat_data_in[slice_lo(g, WIDTH) +: WIDTH]),
            .head_c (head[g]),
            .empty  (empty[g]),
            .full   (full[g])
        );
    end

    // DWRR decision for the single requestor at ptr
    always_comb begin
        gnt          = '0;
        ptr_nxt      = ptr;
        credited_nxt = credited;
        def_we       = 1'b0;
        cur_def      = deficit[ptr];
        def_nxt      = cur_def;
        sum          = {1'b0, cur_def} + SW'(quantum[ptr]);
        // Quantum is added once per visit, saturating at the deficit maximum
        eff          = credited ? cur_def : (sum[DWID] ? DMAX : sum[DWID-1:0]);
        ptr_adv      = (ptr == PW'(NUM_REQS - 1)) ? '0 : ptr + PW'(1);

        if (rst && !blk) begin
            def_we = 1'b1;
            if (empty[ptr]) begin
                def_nxt      = '0;
                ptr_nxt      = ptr_adv;
                credited_nxt = 1'b0;
            end else if (eff >= DWID'(PSIZE)) begin
                gnt[ptr]     = 1'b1;
                def_nxt      = eff - DWID'(PSIZE);
                credited_nxt = 1'b1;
            end else begin
                def_nxt      = eff;
                ptr_nxt      = ptr_adv;
                credited_nxt = 1'b0;
            end
        end
    end

    // Granted head onto the shared output, zero when idle
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (gnt[i]) data_out = head[i];
        end
        data_out_vld = |gnt;
    end

    // Arbiter state
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            credited <= 1'b0;
            for (int i = 0; i < NUM_REQS; i++) deficit[i] <= '0;
        end else begin
            ptr      <= ptr_nxt;
            credited <= credited_nxt;
            if (def_we) deficit[ptr] <= def_nxt;
        end
    end

endmodule

// File: tb/tb_dwrr_queue_arbiter.sv
// Self-checking bench for dwrr_queue_arbiter: a directed vector table,
// hand-written corner sequences, and randomized traffic compared every
// cycle against a queue-based reference model of the DWRR rules.
module tb_dwrr_queue_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int D     = 8;
    localparam int QW    = 8;
    localparam int PS    = 8;
    localparam int DMAXI = 511;

    logic           clk = 1'b0;
    logic           rst;
    logic           blk;
    logic [N-1:0]   push;
    logic [N*W-1:0] flat_data_in;
    logic [N*QW-1:0] input_quantums;
    logic [N-1:0]   gnt;
    logic [W-1:0]   data_out;
    logic           data_out_vld;
    logic [N-1:0]   empty;
    logic [N-1:0]   full;

    dwrr_queue_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .flat_data_in   (flat_data_in),
        .input_quantums (input_quantums),
        .blk            (blk),
        .gnt            (gnt),
        .data_out       (data_out),
        .data_out_vld   (data_out_vld),
        .empty          (empty),
        .full           (full)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int mq [N][$];
    int mdef [N];
    int mptr;
    bit mcred;
    int quant [N];

    // Last sampled DUT outputs
    logic [N-1:0] s_gnt;
    logic [W-1:0] s_data;
    logic         s_vld;
    logic [N-1:0] s_empty;
    logic [N-1:0] s_full;

    typedef struct {
        bit         r;
        bit         b;
        logic [3:0] pu;
        logic [7:0] d;
        logic [3:0] e_gnt;
        logic [7:0] e_data;
        logic [3:0] e_empty;
    } vec_t;

    vec_t tab [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_of(input int p);
        int s;
        if (mcred) return mdef[p];
        s = mdef[p] + quant[p];
        return (s > DMAXI) ? DMAXI : s;
    endfunction

    function automatic int predict(input bit r, input bit b);
        if (!r || b) return -1;
        if (mq[mptr].size() == 0) return -1;
        if (eff_of(mptr) >= PS) return mptr;
        return -1;
    endfunction

    task automatic model_update(input bit r, input bit b, input logic [N-1:0] pu, input logic [N*W-1:0] d);
        bit fpre [N];
        int p;
        int e;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                mdef[i] = 0;
            end
            mptr  = 0;
            mcred = 0;
            return;
        end
        for (int i = 0; i < N; i++) fpre[i] = (mq[i].size() == D);
        if (!b) begin
            p = mptr;
            e = eff_of(p);
            if (mq[p].size() == 0) begin
                mdef[p] = 0;
                mptr    = (p + 1) % N;
                mcred   = 0;
            end else if (e >= PS) begin
                mdef[p] = e - PS;
                mcred   = 1;
                void'(mq[p].pop_front());
            end else begin
                mdef[p] = e;
                mptr    = (p + 1) % N;
                mcred   = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pu[i] && !fpre[i]) mq[i].push_back(int'(d[i*W +: W]));
        end
    endtask

    // One clock: drive, sample mid-cycle, compare with model, advance model
    task automatic run_cycle(input bit r, input bit b, input logic [N-1:0] pu, input logic [N*W-1:0] d);
        int g;
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        logic [N-1:0] ee;
        logic [N-1:0] ef;
        rst          = r;
        blk          = b;
        push         = pu;
        flat_data_in = d;
        for (int i = 0; i < N; i++) input_quantums[i*QW +: QW] = 8'(quant[i]);
        @(negedge clk);
        s_gnt   = gnt;
        s_data  = data_out;
        s_vld   = data_out_vld;
        s_empty = empty;
        s_full  = full;
        g  = predict(r, b);
        eg = '0;
        ed = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ed    = 8'(mq[g][0]);
        end
        for (int i = 0; i < N; i++) begin
            ee[i] = (mq[i].size() == 0);
            ef[i] = (mq[i].size() == D);
        end
        check("gnt", 32'(s_gnt), 32'(eg));
        check("data_out", 32'(s_data), 32'(ed));
        check("data_out_vld", 32'(s_vld), 32'(g >= 0));
        check("empty", 32'(s_empty), 32'(ee));
        check("full", 32'(s_full), 32'(ef));
        model_update(r, b, pu, d);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit r, input bit b, input logic [3:0] pu, input logic [7:0] d,
                                input logic [3:0] eg, input logic [7:0] ed, input logic [3:0] ee);
        vec_t v;
        v.r = r; v.b = b; v.pu = pu; v.d = d;
        v.e_gnt = eg; v.e_data = ed; v.e_empty = ee;
        return v;
    endfunction

    task automatic set_quant(input int q0, input int q1, input int q2, input int q3);
        quant[0] = q0; quant[1] = q1; quant[2] = q2; quant[3] = q3;
    endtask

    task automatic load_all();
        for (int k = 0; k < D; k++) run_cycle(1, 1, 4'hF, {4{8'(8'h40 + k)}});
    endtask

    task automatic check_pattern(input string name, input logic [3:0] pat [9]);
        for (int c = 0; c < 9; c++) begin
            run_cycle(1, 0, 4'h0, '0);
            check(name, 32'(s_gnt), 32'(pat[c]));
        end
    endtask

    initial begin
        logic [3:0] pat [9];
        int ngr;
        int cnt0;
        int cnt1;
        int burst;
        bit seen;
        bit done;
        logic [N*W-1:0] rd;

        set_quant(8, 8, 8, 8);
        mptr = 0;
        mcred = 0;
        for (int i = 0; i < N; i++) mdef[i] = 0;
        rst = 1'b0; blk = 1'b0; push = '0; flat_data_in = '0; input_quantums = '0;
        @(posedge clk);
        #1;

        // Reset hold and single-source drain, expectations written out by hand
        tab[0]  = mk(0, 0, 4'hF, 8'h55, 4'h0, 8'h00, 4'hF);
        tab[1]  = mk(0, 0, 4'hF, 8'h55, 4'h0, 8'h00, 4'hF);
        tab[2]  = mk(1, 1, 4'h1, 8'hA1, 4'h0, 8'h00, 4'hF);
        tab[3]  = mk(1, 1, 4'h1, 8'hA2, 4'h0, 8'h00, 4'hE);
        tab[4]  = mk(1, 1, 4'h1, 8'hA3, 4'h0, 8'h00, 4'hE);
        tab[5]  = mk(1, 0, 4'h0, 8'h00, 4'h1, 8'hA1, 4'hE);
        for (int k = 6; k <= 9; k++) tab[k] = mk(1, 0, 4'h0, 8'h00, 4'h0, 8'h00, 4'hE);
        tab[10] = mk(1, 0, 4'h0, 8'h00, 4'h1, 8'hA2, 4'hE);
        for (int k = 11; k <= 14; k++) tab[k] = mk(1, 0, 4'h0, 8'h00, 4'h0, 8'h00, 4'hE);
        tab[15] = mk(1, 0, 4'h0, 8'h00, 4'h1, 8'hA3, 4'hE);
        tab[16] = mk(1, 0, 4'h0, 8'h00, 4'h0, 8'h00, 4'hF);

        for (int k = 0; k < 17; k++) begin
            run_cycle(tab[k].r, tab[k].b, tab[k].pu, {4{tab[k].d}});
            check("tab_gnt", 32'(s_gnt), 32'(tab[k].e_gnt));
            check("tab_data", 32'(s_data), 32'(tab[k].e_data));
            check("tab_vld", 32'(s_vld), 32'(tab[k].e_gnt != 0));
            check("tab_empty", 32'(s_empty), 32'(tab[k].e_empty));
        end

        // Full/drop on FIFO2: ninth push is lost
        for (int k = 1; k <= 9; k++) run_cycle(1, 1, 4'b0100, {4{8'(k)}});
        check("full2_after8", 32'(s_full[2]), 32'd1);
        ngr = 0;
        for (int c = 0; c < 60; c++) begin
            run_cycle(1, 0, 4'h0, '0);
            if (s_gnt[2]) begin
                ngr++;
                check("drop_data", 32'(s_data), 32'(ngr));
            end
        end
        check("drop_count", 32'(ngr), 32'd8);

        // Weighting: quantum 16 gives two grants per visit
        set_quant(16, 8, 8, 8);
        run_cycle(0, 0, 4'h0, '0);
        load_all();
        pat = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
        check_pattern("wt_pat", pat);
        cnt0 = 2; cnt1 = 1;
        for (int c = 0; c < 27; c++) begin
            run_cycle(1, 0, 4'h0, '0);
            if (s_gnt[0]) cnt0++;
            if (s_gnt[1]) cnt1++;
        end
        check("wt_cnt0", 32'(cnt0), 32'd8);
        check("wt_cnt1", 32'(cnt1), 32'd4);
        for (int c = 0; c < 50; c++) run_cycle(1, 0, 4'h0, '0);

        // Sub-PSIZE quantum: requestor 0 granted every second visit
        set_quant(4, 8, 8, 8);
        run_cycle(0, 0, 4'h0, '0);
        load_all();
        pat = '{4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
        check_pattern("sub_pat", pat);
        for (int c = 0; c < 120; c++) run_cycle(1, 0, 4'h0, '0);

        // Emptied requestor forfeits its leftover deficit
        set_quant(8, 16, 8, 8);
        run_cycle(0, 0, 4'h0, '0);
        run_cycle(1, 1, 4'b0010, {4{8'h77}});
        run_cycle(1, 0, 4'h0, '0);
        check("dr_skip0", 32'(s_gnt), 32'h0);
        run_cycle(1, 0, 4'h0, '0);
        check("dr_first", 32'(s_gnt), 32'h2);
        run_cycle(1, 0, 4'h0, '0);
        check("dr_advance", 32'(s_gnt), 32'h0);
        for (int k = 0; k < 3; k++) run_cycle(1, 1, 4'b0010, {4{8'(8'h80 + k)}});
        burst = 0; seen = 0; done = 0;
        for (int c = 0; c < 12; c++) begin
            run_cycle(1, 0, 4'h0, '0);
            if (s_gnt[1] && !done) begin
                burst++;
                seen = 1;
            end else if (seen) begin
                done = 1;
            end
        end
        check("dr_burst", 32'(burst), 32'd2);
        for (int c = 0; c < 20; c++) run_cycle(1, 0, 4'h0, '0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) begin
                for (int i = 0; i < N; i++) begin
                    quant[i] = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 24));
                end
            end
            for (int i = 0; i < N; i++) rd[i*W +: W] = 8'($urandom);
            run_cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 4) == 0),
                      4'($urandom) & 4'($urandom), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dwrr_queue_arbiter.md
Name: dwrr_queue_arbiter

Overview:
- Multi-requestor ingress block: NUM_REQS synchronous FIFOs, one per requestor, drained by a deficit-weighted round-robin (DWRR) arbiter.
- The arbiter grant pops the selected FIFO in the same cycle and muxes its head onto a single output.
- Sits between per-source packet producers and a shared single-beat consumer.
- Used as the DUT under the data-integrity scoreboard.

Parameters:
- NUM_REQS, 4, number of requestors/FIFOs.
- WIDTH, 8, data width of each entry.
- DEPTH, 8, entries per FIFO (power of two).
- QWID, 8, width of each quantum.
- PSIZE, 8, credit cost per granted entry. Must satisfy 0 < PSIZE < 2^QWID.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- push  in  NUM_REQS  per-FIFO push strobe.
- flat_data_in  in  NUM_REQS*WIDTH  FIFO i data in bits [(i+1)*WIDTH-1 : i*WIDTH].
- input_quantums  in  NUM_REQS*QWID  quantum for requestor i, same slicing.
- blk  in  1  1 = suppress all grants this cycle.
- gnt  out  NUM_REQS  one-hot grant; equals the pop of each FIFO.
- data_out  out  WIDTH  head of granted FIFO; 0 when no grant.
- data_out_vld  out  1  equals |gnt.
- empty  out  NUM_REQS  per-FIFO empty (registered count == 0).
- full  out  NUM_REQS  per-FIFO full (count == DEPTH).

Behaviour:
- Reset: on a clk edge with rst==0:
  - all FIFO pointers and counts go to 0;
  - arbiter pointer ptr goes to 0; all deficits go to 0; credited goes to 0.
  - While rst==0, gnt=0, data_out=0 and data_out_vld=0 (combinationally forced).
  - After the reset edge: empty=all ones, full=0.
- FIFO (per requestor):
  - Count is CNTWID = clog2(DEPTH)+1 bits.
  - A push is accepted iff push[i] && !full[i]; a push to a full FIFO is dropped, even if that FIFO is popped in the same cycle.
  - A pop occurs iff gnt[i]; gnt is never asserted for an empty FIFO.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Read and write pointers wrap modulo DEPTH.
  - The head is readable combinationally; order is strict FIFO.
- Arbiter:
  - reqs[i] = ~empty[i].
  - Per-requestor state: deficit[i], QWID+1 bits, saturating at its maximum.
  - Shared state: ptr (clog2(NUM_REQS) bits) and credited (1 bit, set once the quantum has been added for the current visit).
  - Each cycle, with rst==1 and blk==0, evaluate requestor p = ptr:
    - eff = credited ? deficit[p] : sat(deficit[p] + quantum[p]).
    - If !reqs[p]: no grant; deficit[p] <= 0; ptr <= p+1 (mod NUM_REQS); credited <= 0.
    - Else if eff >= PSIZE: gnt[p]=1 this cycle; deficit[p] <= eff - PSIZE; credited <= 1; ptr unchanged.
    - Else: no grant; deficit[p] <= eff; ptr advances; credited <= 0.
  - If blk==1: gnt=0 and no arbiter state changes. FIFO pushes still occur.
  - Grant latency is 0 cycles from state: gnt, data_out and the pop all happen in the same cycle.
  - Each visit ends with one non-grant cycle (the advance cycle).
  - quantum[p]==0 with zero deficit: requestor p is never granted and is skipped each visit.
  - Only the one requestor at ptr is evaluated per cycle.

Decomposition:
- Shared package holds:
  - default parameter constants;
  - the CNTWID and deficit-width functions (clog2(DEPTH)+1 and QWID+1);
  - the slice-index helper for the flattened buses.
- One natural sub-module: dwrr_req_fifo (single synchronous FIFO with full/empty and a combinational head), generated NUM_REQS times.
- The DWRR logic and output mux stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with push=4'b1111 -> empty=4'b1111, full=0, gnt=0, data_out_vld=0; no entries stored.
- Single source, quantums all 8: push 0xA1,0xA2,0xA3 into FIFO0 with blk=1, then blk=0 -> gnt=4'b0001 with data_out 0xA1, then idle, then 0xA2, then idle, then 0xA3 (one grant per visit; 3 idle advance cycles through requestors 1..3 between grants) -> empty[0]=1.
- Weighting: FIFOs 0..3 each hold 8 entries; quantums 16,8,8,8 -> per round the grant pattern is 0,0,idle,1,idle,2,idle,3,idle; FIFO0 drains at twice the rate of the others.
- Sub-PSIZE quantum: quantum0=4, others 8, all FIFOs loaded -> requestor 0 is granted only on every second visit (deficit 4, then 8).
- Full/drop: blk=1, push 9 entries 0x01..0x09 into FIFO2 -> full[2]=1 after the 8th push; 0x09 dropped. Release blk -> exactly 8 grants on FIFO2, data 0x01..0x08.
- Empty reset of deficit: quantum1=16; grant one entry from FIFO1 (deficit 8) until FIFO1 is empty -> its next visit sets deficit[1]=0; a later refill is granted using only the fresh quantum.
